// File: rtl/gcd_ci_pkg.sv
// Shared types and constants for the GCD custom-instruction unit.
package gcd_ci_pkg;

  localparam int WIDTH = 32;
  localparam int K_W   = 6;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    STRIP,
    REDUCE,
    FINISH
  } state_t;

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [K_W-1:0]   kcnt_t;

endpackage

// File: rtl/gcd_ci_step.sv
// One REDUCE iteration of binary GCD: halve an even operand, or replace the
// larger of two odd operands by half their difference.
module gcd_ci_step
  import gcd_ci_pkg::*;
(
  input  word_t u_i,
  input  word_t v_i,
  output word_t u_o,
  output word_t v_o,
  output logic  equal_o
);

  // NOTE: every output gets a default before the if-chain so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    u_o     = u_i;
    v_o     = v_i;
    equal_o = (u_i == v_i);
    if (!equal_o) begin
      if (!u_i[0]) begin
        u_o = u_i >> 1;
      end else if (!v_i[0]) begin
        v_o = v_i >> 1;
      end else if (u_i > v_i) begin
        u_o = (u_i - v_i) >> 1;
      end else begin
        v_o = (v_i - u_i) >> 1;
      end
    end
  end

endmodule

// File: rtl/gcd_ci_core.sv
// Nios II-style multicycle custom instruction computing gcd(dataa, datab)
// with Stein's algorithm; latency bounded by operand width.
module gcd_ci_core
  import gcd_ci_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clk_en,
  input  logic  start,
  input  word_t dataa,
  input  word_t datab,
  output logic  done,
  output word_t result
);

  state_t state_q, state_d;
  word_t  u_q, u_d;
  word_t  v_q, v_d;
  kcnt_t  k_q, k_d;
  word_t  result_q, result_d;

  word_t  step_u, step_v;
  logic   step_equal;

  gcd_ci_step u_step (
    .u_i     (u_q),
    .v_i     (v_q),
    .u_o     (step_u),
    .v_o     (step_v),
    .equal_o (step_equal)
  );

  // Reset wins over clk_en; with clk_en low every register simply holds.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled at the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      u_q      <= '0;
      v_q      <= '0;
      k_q      <= '0;
      result_q <= '0;
    end else if (clk_en) begin
      state_q  <= state_d;
      u_q      <= u_d;
      v_q      <= v_d;
      k_q      <= k_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    u_d      = u_q;
    v_d      = v_q;
    k_d      = k_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          u_d     = dataa;
          v_d     = datab;
          k_d     = '0;
          state_d = INIT;
        end
      end
      INIT: begin
        if (u_q == '0) begin
          result_d = v_q;
          state_d  = FINISH;
        end else if (v_q == '0) begin
          result_d = u_q;
          state_d  = FINISH;
        end else begin
          state_d = STRIP;
        end
      end
      STRIP: begin
        // Common factors of two are removed here and restored via k at the end.
        if (!u_q[0] && !v_q[0]) begin
          u_d = u_q >> 1;
          v_d = v_q >> 1;
          k_d = k_q + kcnt_t'(1);
        end else begin
          state_d = REDUCE;
        end
      end
      REDUCE: begin
        if (step_equal) begin
          result_d = u_q << k_q;
          state_d  = FINISH;
        end else begin
          u_d = step_u;
          v_d = step_v;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign done   = (state_q == FINISH);
  assign result = result_q;

endmodule

// File: tb/tb_gcd_ci_core.sv
// Directed bench for gcd_ci_core: Euclid reference model, per-cycle compare
// process, and hand-computed literal expectations per operation.
module tb_gcd_ci_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic        done;
  logic [31:0] result;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_q[$];
  logic [31:0] held_result = 32'd0;
  bit          run_chk = 1'b0;

  gcd_ci_core dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .start  (start),
    .dataa  (dataa),
    .datab  (datab),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, act, act, exp, exp);
    end
  endtask

  // Euclid's remainder algorithm, deliberately unlike the DUT's binary method.
  function automatic logic [31:0] gcd_model(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] t;
    while (b != 32'd0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Every cycle: a done must match the oldest outstanding op; otherwise result holds.
  initial begin
    logic [31:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (!run_chk) continue;
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", {31'd0, done}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("result_on_done", result, e);
          held_result = e;
        end
      end else begin
        check("done_low", {31'd0, done}, 32'd0);
        check("result_hold", result, held_result);
      end
    end
  end

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] lit,
                        input bit pulse, input int freeze_at, input string name);
    int cyc;
    int en_cyc;
    bit en_prev;
    bit got;
    @(negedge clk);
    dataa = a;
    datab = b;
    start = 1'b1;
    exp_q.push_back(gcd_model(a, b));
    cyc     = 0;
    en_cyc  = 0;
    en_prev = 1'b1;
    got     = 1'b0;
    while (!got && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (en_prev) en_cyc++;
      else check({name, "_frozen_done"}, {31'd0, done}, 32'd0);
      if (done === 1'b1) got = 1'b1;
      if (pulse && cyc == 1) begin
        start = 1'b0;
        dataa = 32'hDEADBEEF;
        datab = 32'd6;
      end
      if (freeze_at > 0 && cyc == freeze_at)     clk_en = 1'b0;
      if (freeze_at > 0 && cyc == freeze_at + 5) clk_en = 1'b1;
      en_prev = clk_en;
    end
    start = 1'b0;
    check({name, "_done_seen"}, {31'd0, got}, 32'd1);
    if (got) begin
      check({name, "_latency_le_100"}, {31'd0, (en_cyc <= 100)}, 32'd1);
      check({name, "_literal"}, result, lit);
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b0;
    clk_en = 1'b0;
    start  = 1'b0;
    dataa  = 32'd0;
    datab  = 32'd0;

    // Reset must take effect even while clk_en is low.
    repeat (3) @(negedge clk);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    rst         = 1'b1;
    clk_en      = 1'b1;
    held_result = 32'd0;
    run_chk     = 1'b1;

    run_op(32'd91, 32'd21, 32'd7, 1'b0, 0, "g91_21");

    run_op(32'd2147483647, 32'd524287, 32'd1, 1'b0, 0, "mersenne");
    run_op(32'd1,          32'd1,      32'd1, 1'b0, 0, "g1_1");
    run_op(32'd1000000000, 32'd1,      32'd1, 1'b0, 0, "g1e9_1");
    run_op(32'd2,          32'd1023,   32'd1, 1'b0, 0, "g2_1023");

    run_op(32'd48,   32'd180,  32'd12,   1'b0, 0, "g48_180");
    run_op(32'd1024, 32'd4096, 32'd1024, 1'b0, 0, "g1024_4096");
    run_op(32'd0,    32'd12,   32'd12,   1'b0, 0, "g0_12");
    run_op(32'd12,   32'd0,    32'd12,   1'b0, 0, "g12_0");
    run_op(32'd0,    32'd0,    32'd0,    1'b0, 0, "g0_0");
    run_op(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0, 0, "k31");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 1'b0, 0, "max_pair");

    run_op(32'd91, 32'd21, 32'd7, 1'b0, 3, "freeze");

    // Abort an operation with reset; no done may follow for it.
    @(negedge clk);
    dataa = 32'd2147483647;
    datab = 32'd524287;
    start = 1'b1;
    exp_q.push_back(gcd_model(32'd2147483647, 32'd524287));
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    held_result = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", result, 32'd0);
    repeat (80) @(negedge clk);
    run_op(32'd91, 32'd21, 32'd7, 1'b0, 0, "after_abort");

    run_op(32'd35, 32'd14, 32'd7, 1'b1, 0, "pulse35_14");

    repeat (5) @(negedge clk);
    check("pending_ops", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
